// File: rtl/scoreboard_bypass_net_if.sv
// ----------------------------------------------------------------------------
// scoreboard_bypass_net_if
// Carries every signal that the issue-stage scoreboard and bypass network
// exchange with the rest of the pipeline. clk and resetn are plain module
// ports and are not part of this interface.
//
// Signals (all vectors are flattened, lowest index in the lowest bits):
//   advance            backend moves one stage this cycle
//   flush              discard all in-flight writers
//   issue_valid        [ISSUE_WIDTH]            line k issues a register writer
//   issue_dest         [ISSUE_WIDTH*5]          destination register per line
//   rd_addr            [READ_PORTS*5]           source register per operand port
//   rf_data            [READ_PORTS*DATA_W]      register-file read data per port
//   stage_result       [STAGES*ISSUE_WIDTH*DATA_W] result of stage s, line k,
//                      at slot (s*ISSUE_WIDTH + k)
//   stage_result_valid [STAGES*ISSUE_WIDTH]     slot (s*ISSUE_WIDTH + k) is final
//   rd_data            [READ_PORTS*DATA_W]      forwarded operand
//   rd_hazard          [READ_PORTS]             operand not yet available
//   stall              whole bundle must be held upstream
//
// Modports:
//   master  pipeline side (drives requests, receives operands)
//   slave   scoreboard side
// ----------------------------------------------------------------------------
interface scoreboard_bypass_net_if #(
    parameter int ISSUE_WIDTH = 2,
    parameter int READ_PORTS  = 4,
    parameter int STAGES      = 3,
    parameter int DATA_W      = 32
);
    logic                                 advance;
    logic                                 flush;
    logic [ISSUE_WIDTH-1:0]               issue_valid;
    logic [ISSUE_WIDTH*5-1:0]             issue_dest;
    logic [READ_PORTS*5-1:0]              rd_addr;
    logic [READ_PORTS*DATA_W-1:0]         rf_data;
    logic [STAGES*ISSUE_WIDTH*DATA_W-1:0] stage_result;
    logic [STAGES*ISSUE_WIDTH-1:0]        stage_result_valid;
    logic [READ_PORTS*DATA_W-1:0]         rd_data;
    logic [READ_PORTS-1:0]                rd_hazard;
    logic                                 stall;

    modport master (
        output advance, flush, issue_valid, issue_dest, rd_addr, rf_data,
               stage_result, stage_result_valid,
        input  rd_data, rd_hazard, stall
    );

    modport slave (
        input  advance, flush, issue_valid, issue_dest, rd_addr, rf_data,
               stage_result, stage_result_valid,
        output rd_data, rd_hazard, stall
    );
endinterface

// File: rtl/scoreboard_bypass_net.sv
// ----------------------------------------------------------------------------
// scoreboard_bypass_net
// Issue-stage scoreboard and operand-forwarding network for the multi-issue
// pipeline. For every architectural register (except r0) it remembers the
// newest in-flight writer: which backend stage it is in (one-hot) and which
// issue line produced it. Operand ports look up their source register and
// either take the register-file value, take a forwarded stage result, or
// raise a hazard when the producing stage has not finished yet. Any hazard on
// a port belonging to an issuing line stalls the whole bundle.
//
// Ports:
//   clk           clock, rising edge
//   resetn        asynchronous active-low reset, clears every entry
//   bus           scoreboard_bypass_net_if.slave (issue, read and result buses)
//   stall_cycles  [31:0] count of stalled cycles, only when
//                 BYPASS_STALL_CNT_EN is defined
//
// Optional feature macro: BYPASS_STALL_CNT_EN (adds the stall_cycles counter).
// ----------------------------------------------------------------------------
module scoreboard_bypass_net #(
    parameter int ISSUE_WIDTH = 2,
    parameter int READ_PORTS  = 4,
    parameter int STAGES      = 3,
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    scoreboard_bypass_net_if.slave  bus
`ifdef BYPASS_STALL_CNT_EN
    ,
    output logic [31:0]             stall_cycles
`endif
);

    localparam int PORTS_PER_LINE = READ_PORTS / ISSUE_WIDTH;
    localparam int LINE_W         = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;

    logic [NUM_REGS-1:0] valid_q, valid_d;
    logic [STAGES-1:0]   pos_q  [NUM_REGS];
    logic [STAGES-1:0]   pos_d  [NUM_REGS];
    logic [LINE_W-1:0]   line_q [NUM_REGS];
    logic [LINE_W-1:0]   line_d [NUM_REGS];

    logic [4:0]            lk_reg;
    logic [READ_PORTS-1:0] hazard_c;
    logic                  stall_c;

    // Operand lookup: start from the register file, then let a tracked writer
    // either supply its finished result or mark the port as waiting. An older
    // line in the same bundle writing the same register always wins over
    // forwarding, because its value does not exist anywhere yet.
    always_comb begin
        bus.rd_data = bus.rf_data;
        hazard_c    = '0;
        lk_reg      = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            lk_reg = bus.rd_addr[p*5 +: 5];
            if (lk_reg != 5'd0 && valid_q[lk_reg]) begin
                for (int s = 0; s < STAGES; s++) begin
                    for (int k = 0; k < ISSUE_WIDTH; k++) begin
                        if (pos_q[lk_reg][s] && line_q[lk_reg] == LINE_W'(k)) begin
                            if (bus.stage_result_valid[s*ISSUE_WIDTH + k]) begin
                                bus.rd_data[p*DATA_W +: DATA_W] =
                                    bus.stage_result[(s*ISSUE_WIDTH + k)*DATA_W +: DATA_W];
                            end else begin
                                hazard_c[p] = 1'b1;
                            end
                        end
                    end
                end
            end
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                if (i < p / PORTS_PER_LINE && bus.issue_valid[i] &&
                    bus.issue_dest[i*5 +: 5] == lk_reg && lk_reg != 5'd0) begin
                    hazard_c[p]                     = 1'b1;
                    bus.rd_data[p*DATA_W +: DATA_W] = bus.rf_data[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Only ports of lines that actually issue this cycle can hold the bundle.
    always_comb begin
        stall_c = 1'b0;
        for (int p = 0; p < READ_PORTS; p++) begin
            if (bus.issue_valid[p / PORTS_PER_LINE] && hazard_c[p]) begin
                stall_c = 1'b1;
            end
        end
    end

    assign bus.rd_hazard = hazard_c;
    assign bus.stall     = stall_c;

    // Next scoreboard state. Shifting is applied first and new writes last, so
    // a fresh writer replaces whatever the older one was doing (newest wins),
    // and the ascending line loop lets the higher line win a same-dest tie.
    always_comb begin
        valid_d = valid_q;
        pos_d   = pos_q;
        line_d  = line_q;
        if (bus.flush) begin
            valid_d = '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                pos_d[r]  = '0;
                line_d[r] = '0;
            end
        end else if (bus.advance) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (valid_q[r]) begin
                    if (pos_q[r][STAGES-1]) begin
                        valid_d[r] = 1'b0;
                        pos_d[r]   = '0;
                    end else begin
                        pos_d[r] = pos_q[r] << 1;
                    end
                end
            end
            if (!stall_c) begin
                for (int k = 0; k < ISSUE_WIDTH; k++) begin
                    if (bus.issue_valid[k] && bus.issue_dest[k*5 +: 5] != 5'd0) begin
                        valid_d[bus.issue_dest[k*5 +: 5]] = 1'b1;
                        pos_d[bus.issue_dest[k*5 +: 5]]   = STAGES'(1);
                        line_d[bus.issue_dest[k*5 +: 5]]  = LINE_W'(k);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                pos_q[r]  <= '0;
                line_q[r] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            pos_q   <= pos_d;
            line_q  <= line_d;
        end
    end

`ifdef BYPASS_STALL_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Free-running stall counter; wraps naturally and ignores flush.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_c) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_scoreboard_bypass_net.sv
// ----------------------------------------------------------------------------
// tb_scoreboard_bypass_net
// Self-checking bench for scoreboard_bypass_net. A reference model keeps, per
// register, the age (stage number) and line of the newest writer as plain
// integers and derives the expected operands, hazards and stall from them.
// Directed scenarios cover forwarding through each stage, load-use hazards,
// intra-bundle dependencies, same-dest ties, flush, r0 and async reset; a
// randomized phase follows.
// ----------------------------------------------------------------------------
module tb_scoreboard_bypass_net;

    localparam int IW  = 2;
    localparam int RP  = 4;
    localparam int ST  = 3;
    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int PPL = RP / IW;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    scoreboard_bypass_net_if #(.ISSUE_WIDTH(IW), .READ_PORTS(RP), .STAGES(ST), .DATA_W(DW)) bus ();

`ifdef BYPASS_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    scoreboard_bypass_net #(
        .ISSUE_WIDTH(IW), .READ_PORTS(RP), .STAGES(ST), .DATA_W(DW), .NUM_REGS(NR)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
`ifdef BYPASS_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    int compare_count;
    int mismatch_count;

    // Reference model: newest writer per register, age counted in stages.
    bit          m_valid [NR];
    int          m_stage [NR];
    int          m_line  [NR];
    logic [31:0] m_stall_cnt;

    logic [DW-1:0] exp_data [RP];
    logic [RP-1:0] exp_haz;
    logic          exp_stall;

    // Single comparison point; every check is counted here.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelClear();
        for (int r = 0; r < NR; r++) begin
            m_valid[r] = 1'b0;
            m_stage[r] = 0;
            m_line[r]  = 0;
        end
        m_stall_cnt = 32'd0;
    endtask

    // Expected operands for the current inputs and model state.
    task automatic modelEval();
        logic [4:0] r;
        int slot;
        exp_stall = 1'b0;
        for (int p = 0; p < RP; p++) begin
            r           = bus.rd_addr[p*5 +: 5];
            exp_data[p] = bus.rf_data[p*DW +: DW];
            exp_haz[p]  = 1'b0;
            if (r != 0 && m_valid[r]) begin
                slot = m_stage[r] * IW + m_line[r];
                if (bus.stage_result_valid[slot]) exp_data[p] = bus.stage_result[slot*DW +: DW];
                else exp_haz[p] = 1'b1;
            end
            for (int i = 0; i < p / PPL; i++) begin
                if (bus.issue_valid[i] && bus.issue_dest[i*5 +: 5] == r && r != 0) begin
                    exp_haz[p]  = 1'b1;
                    exp_data[p] = bus.rf_data[p*DW +: DW];
                end
            end
            if (exp_haz[p] && bus.issue_valid[p / PPL]) exp_stall = 1'b1;
        end
    endtask

    // Clock-edge update of the model, using the stall just evaluated.
    task automatic modelUpdate();
        logic [4:0] d;
        if (exp_stall) m_stall_cnt = m_stall_cnt + 32'd1;
        if (bus.flush) begin
            for (int r = 0; r < NR; r++) m_valid[r] = 1'b0;
        end else if (bus.advance) begin
            for (int r = 1; r < NR; r++) begin
                if (m_valid[r]) begin
                    m_stage[r]++;
                    if (m_stage[r] >= ST) m_valid[r] = 1'b0;
                end
            end
            if (!exp_stall) begin
                for (int k = 0; k < IW; k++) begin
                    d = bus.issue_dest[k*5 +: 5];
                    if (bus.issue_valid[k] && d != 0) begin
                        m_valid[d] = 1'b1;
                        m_stage[d] = 0;
                        m_line[d]  = k;
                    end
                end
            end
        end
    endtask

    // Check the current cycle against the model, then step one clock.
    task automatic applyStimulus(input string tag);
        #2;
        modelEval();
        for (int p = 0; p < RP; p++)
            checkOutput($sformatf("%s rd_data[%0d]", tag, p), 64'(bus.rd_data[p*DW +: DW]), 64'(exp_data[p]));
        checkOutput({tag, " rd_hazard"}, 64'(bus.rd_hazard), 64'(exp_haz));
        checkOutput({tag, " stall"}, 64'(bus.stall), 64'(exp_stall));
        modelUpdate();
        @(posedge clk);
        #1;
`ifdef BYPASS_STALL_CNT_EN
        checkOutput({tag, " stall_cycles"}, 64'(stall_cycles), 64'(m_stall_cnt));
`endif
    endtask

    task automatic setDefaults();
        bus.advance            = 1'b0;
        bus.flush              = 1'b0;
        bus.issue_valid        = '0;
        bus.issue_dest         = '0;
        bus.rd_addr            = '0;
        bus.stage_result_valid = '0;
        for (int p = 0; p < RP; p++) bus.rf_data[p*DW +: DW] = $urandom;
        for (int s = 0; s < ST*IW; s++) bus.stage_result[s*DW +: DW] = $urandom;
    endtask

    task automatic setAddr(input int p, input logic [4:0] r);
        bus.rd_addr[p*5 +: 5] = r;
    endtask

    task automatic setIssue(input int k, input logic [4:0] d);
        bus.issue_valid[k]       = 1'b1;
        bus.issue_dest[k*5 +: 5] = d;
    endtask

    task automatic setResult(input int s, input int k, input logic [DW-1:0] v);
        bus.stage_result[(s*IW + k)*DW +: DW] = v;
        bus.stage_result_valid[s*IW + k]      = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < ST; i++) begin
            setDefaults();
            bus.advance = 1'b1;
            applyStimulus("drain");
        end
    endtask

    logic [31:0] base_cnt;

    initial begin
        compare_count  = 0;
        mismatch_count = 0;
        modelClear();

        // Reset state: plain register-file pass-through.
        resetn = 1'b0;
        setDefaults();
        setAddr(0, 5'd5);
        bus.rf_data[0 +: DW] = 32'h11;
        #3;
        checkOutput("reset rd_data0", 64'(bus.rd_data[0 +: DW]), 64'h11);
        checkOutput("reset rd_hazard", 64'(bus.rd_hazard), 64'h0);
        checkOutput("reset stall", 64'(bus.stall), 64'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Writer of r5 forwarded from execute, memory and commit, then gone.
        setDefaults(); setIssue(0, 5'd5); bus.advance = 1'b1;
        applyStimulus("issue5");
        for (int s = 0; s < ST; s++) begin
            setDefaults(); setAddr(0, 5'd5); setResult(s, 0, 32'hAA); bus.advance = 1'b1;
            #2;
            checkOutput($sformatf("fwd r5 stage%0d", s), 64'(bus.rd_data[0 +: DW]), 64'hAA);
            applyStimulus("fwd5");
        end
        setDefaults(); setAddr(0, 5'd5); setResult(0, 0, 32'hBB);
        #2;
        checkOutput("r5 retired", 64'(bus.rd_data[0 +: DW]), 64'(bus.rf_data[0 +: DW]));
        applyStimulus("retired5");

        // Load-use: r7 in execute, result not ready.
        setDefaults(); setIssue(1, 5'd7); bus.advance = 1'b1;
        applyStimulus("issue7");
        setDefaults(); setAddr(0, 5'd7); setIssue(0, 5'd0); bus.advance = 1'b1;
        #2;
        checkOutput("load hazard", 64'(bus.rd_hazard[0]), 64'h1);
        checkOutput("load stall", 64'(bus.stall), 64'h1);
        applyStimulus("load_wait");
        setDefaults(); setAddr(0, 5'd7); setIssue(0, 5'd0); setResult(1, 1, 32'h77); bus.advance = 1'b1;
        #2;
        checkOutput("load ready hazard", 64'(bus.rd_hazard[0]), 64'h0);
        checkOutput("load ready data", 64'(bus.rd_data[0 +: DW]), 64'h77);
        applyStimulus("load_ready");
        drain();

        // Intra-bundle dependency: line1 reads what line0 writes.
        setDefaults(); setIssue(0, 5'd9); setIssue(1, 5'd0); setAddr(2, 5'd9); bus.advance = 1'b1;
        #2;
        checkOutput("bundle hazard", 64'(bus.rd_hazard[2]), 64'h1);
        checkOutput("bundle stall", 64'(bus.stall), 64'h1);
        applyStimulus("bundle_dep");
        setDefaults(); setAddr(0, 5'd9); setResult(0, 0, 32'h5);
        #2;
        checkOutput("stalled write dropped", 64'(bus.rd_data[0 +: DW]), 64'(bus.rf_data[0 +: DW]));
        applyStimulus("no_entry9");
        // Same destination on both lines: line1 must own the entry.
        setDefaults(); setIssue(0, 5'd9); setIssue(1, 5'd9); bus.advance = 1'b1;
        applyStimulus("waw9");
        setDefaults(); setAddr(0, 5'd9); setResult(0, 1, 32'h99); setResult(0, 0, 32'h55);
        #2;
        checkOutput("waw line1 wins", 64'(bus.rd_data[0 +: DW]), 64'h99);
        applyStimulus("waw9_read");
        drain();

        // Flush drops both old entries and the bundle issued alongside it.
        setDefaults(); setIssue(0, 5'd3); setIssue(1, 5'd4); bus.advance = 1'b1;
        applyStimulus("issue34");
        setDefaults(); setIssue(0, 5'd3); setIssue(1, 5'd4); bus.advance = 1'b1; bus.flush = 1'b1;
        applyStimulus("flush");
        setDefaults(); setAddr(0, 5'd3); setAddr(1, 5'd4); bus.stage_result_valid = '1;
        #2;
        checkOutput("flush r3", 64'(bus.rd_data[0 +: DW]), 64'(bus.rf_data[0 +: DW]));
        checkOutput("flush r4", 64'(bus.rd_data[DW +: DW]), 64'(bus.rf_data[DW +: DW]));
        checkOutput("flush hazard", 64'(bus.rd_hazard), 64'h0);
        applyStimulus("after_flush");

        // r0 is never tracked.
        setDefaults(); setIssue(0, 5'd0); setIssue(1, 5'd0); bus.advance = 1'b1;
        applyStimulus("issue_r0");
        setDefaults(); bus.issue_valid = 2'b11;
        #2;
        checkOutput("r0 hazard", 64'(bus.rd_hazard), 64'h0);
        checkOutput("r0 data", 64'(bus.rd_data[DW*3 +: DW]), 64'(bus.rf_data[DW*3 +: DW]));
        applyStimulus("read_r0");

        // Three stalled cycles while holding the backend.
        setDefaults(); setIssue(1, 5'd12); bus.advance = 1'b1;
        applyStimulus("issue12");
        base_cnt = m_stall_cnt;
        for (int i = 0; i < 3; i++) begin
            setDefaults(); setIssue(0, 5'd0); setAddr(0, 5'd12);
            applyStimulus("hold12");
        end
`ifdef BYPASS_STALL_CNT_EN
        checkOutput("stall_cycles +3", 64'(stall_cycles), 64'(base_cnt + 32'd3));
`endif
        drain();

        // Randomized traffic over a small register window to force overlap.
        for (int n = 0; n < 400; n++) begin
            setDefaults();
            bus.advance            = ($urandom_range(0, 3) != 0);
            bus.flush              = ($urandom_range(0, 19) == 0);
            bus.issue_valid        = IW'($urandom);
            bus.stage_result_valid = (ST*IW)'($urandom);
            for (int k = 0; k < IW; k++) bus.issue_dest[k*5 +: 5] = 5'($urandom_range(0, 7));
            for (int p = 0; p < RP; p++) setAddr(p, 5'($urandom_range(0, 7)));
            if (n == 200) begin
                resetn = 1'b0;
                #1;
                checkOutput("async reset hazard", 64'(bus.rd_hazard), 64'h0);
                checkOutput("async reset data0", 64'(bus.rd_data[0 +: DW]), 64'(bus.rf_data[0 +: DW]));
`ifdef BYPASS_STALL_CNT_EN
                checkOutput("async reset stall_cycles", 64'(stall_cycles), 64'h0);
`endif
                modelClear();
                resetn = 1'b1;
            end
            applyStimulus("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
